load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Core-side initiator for the word-addressed data memory. It accepts one load or store per
//  handshake and issues the word access. It performs byte/halfword lane select with sign or zero
//  extension for loads, and read-modify-write for SB/SH, because the memory only writes full words.
//  It sits between the execute stage and the data memory. At most one access is in flight.
// PARAMETERS
//  DATA_W     32   core data width and memory word width
//  ADDR_W     32   core byte-address width
//  MEM_DEPTH  100  memory depth in words; word index >= MEM_DEPTH is out of range
// PORTS
//  CLK         in   1       clock, rising edge
//  RST         in   1       asynchronous reset, active-high
//  req_valid   in   1       core request valid
//  req_ready   out  1       LSU idle, can accept a request
//  req_we      in   1       1 = store, 0 = load
//  req_funct3  in   3       RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   DATA_W  store data, right-aligned
//  rsp_valid   out  1       one-cycle completion pulse
//  rsp_rdata   out  DATA_W  extended load data; 0 for stores and on error
//  rsp_err     out  1       qualified by rsp_valid: illegal funct3, out of range, or misaligned
//  mem_A       out  ADDR_W  word index to memory (byte addr >> 2)
//  mem_WE      out  1       memory write enable
//  mem_WD      out  DATA_W  memory write data
//  mem_RD      in   DATA_W  memory combinational read data for mem_A
// BEHAVIOUR
//  - FSM states: IDLE, READ, WRITE, RESP. Every output is decoded from registered state and latches.
//  - Reset, asynchronous: state=IDLE, latches=0. Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0,
//    rsp_err=0, mem_WE=0, mem_A=0, mem_WD=0. Requests are ignored while RST=1.
//  - IDLE: req_ready=1. On req_valid=1, latch we, funct3, addr, wdata. Then go to:
//    * RESP with err=1 if the request is in error (illegal funct3, word index >= MEM_DEPTH,
//      or a trapped misalignment).
//    * WRITE for SW.
//    * READ for any load, SB or SH.
//  - READ, 1 cycle: mem_A=addr>>2, mem_WE=0, capture mem_RD into rbuf.
//    Next state: RESP for a load; WRITE for SB/SH.
//  - WRITE, 1 cycle: mem_WE=1, mem_A=addr>>2. mem_WD is:
//    * wdata for SW;
//    * for SB/SH, rbuf with lane addr[1:0] (SB) or half addr[1] (SH) replaced by the low bits of wdata.
//    Next state: RESP.
//  - RESP, 1 cycle: rsp_valid=1. rsp_rdata carries the selected lane of rbuf:
//    * LB/LH: sign-extended;  LBU/LHU: zero-extended;  LW: full rbuf.
//    Return to IDLE; a new request can be accepted in the next cycle. Responses have no backpressure.
//  - Latency from the accept edge to rsp_valid:
//    LW 2 cycles, SW 2 cycles, LB/LH/LBU/LHU 2 cycles, SB/SH 3 cycles, error 1 cycle.
//  - On error: no memory read or write occurs, mem_WE stays 0, rsp_rdata=0.
//  - Sub-word lanes use little-endian order: lane 0 is bits 7:0.
//  - Reset asserted mid-operation (any state): immediate IDLE with mem_WE=0; no partial write,
//    no rsp_valid. The aborted request is lost.
//  - mem_A uses the highest index MEM_DEPTH-1 unchanged; the address check happens before any access.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//    - Halfword access with addr[0]=1 is an error. Word access with addr[1:0]!=0 is an error.
//    - Error handling is as above: rsp_err=1, no memory access.
//  MISALIGN_TRAP_EN undefined:
//    - Alignment is forced: LH/SH ignore addr[0]; LW/SW ignore addr[1:0].
//    - rsp_err is never raised for alignment.
// TESTING
//  1. SW addr=0x8, wdata=0xDEADBEEF
//     -> mem_WE=1 with mem_A=2 in cycle 1; rsp_valid in cycle 2, err=0.
//  2. Word 2=0xDEADBEEF; SB addr=0x9, wdata=0x55
//     -> READ then WRITE with mem_WD=0xDEAD55EF; rsp_valid in cycle 3.
//  3. Word 2=0xDEAD55EF; loads:
//     LB 0xB -> 0xFFFFFFDE;  LBU 0xB -> 0x000000DE;  LH 0xA -> 0xFFFFDEAD;  LHU 0x8 -> 0x000055EF.
//  4. LW addr=0x6:
//     with MISALIGN_TRAP_EN -> rsp_err=1 in cycle 1, no access;
//     without it -> returns word 1.
//  5. SW addr=400 (word 100 = MEM_DEPTH) and funct3=011
//     -> rsp_err=1, mem_WE never asserted, memory unchanged.
//  6. Assert RST during the WRITE state of an SB
//     -> mem_WE=0 immediately, no rsp_valid; after release req_ready=1 and memory is unchanged.

Source files
------------

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and data-memory signals of the load/store unit
interface load_store_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_A;
    logic              mem_WE;
    logic [DATA_W-1:0] mem_WD;
    logic [DATA_W-1:0] mem_RD;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_A, mem_WE, mem_WD
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_A, mem_WE, mem_WD
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store initiator for a word-addressed memory
// Sub-word loads are lane-selected and extended; SB/SH use read-modify-write. Option: MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 100
) (
    input  logic                CLK,
    input  logic                RST,
    load_store_unit_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t            state, state_nx;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rbuf;
    logic              err_q;

    logic              f3_bad, range_bad, misalign_bad, req_err, accept;
    logic [4:0]        byte_sh, half_sh;
    logic [7:0]        byte_ln;
    logic [15:0]       half_ln;
    logic [DATA_W-1:0] merge_wd, load_data;

    // Stores have no unsigned variants, so 1xx is illegal for them.
    assign f3_bad = bus.req_we ? (bus.req_funct3[2] || bus.req_funct3 == 3'b011)
                               : (bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11);
    assign range_bad = (bus.req_addr >> 2) >= ADDR_W'(MEM_DEPTH);
`ifdef MISALIGN_TRAP_EN
    assign misalign_bad = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                          (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
    assign misalign_bad = 1'b0;
`endif
    assign req_err = f3_bad || range_bad || misalign_bad;
    assign accept  = (state == IDLE) && bus.req_valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf    <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                err_q   <= req_err;
            end
            if (state == READ) rbuf <= bus.mem_RD;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_err)                                     state_nx = RESP;
                    else if (bus.req_we && bus.req_funct3[1:0] == 2'b10) state_nx = WRITE;
                    else                                             state_nx = READ;
                end
            end
            READ:    state_nx = we_q ? WRITE : RESP;
            WRITE:   state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Halfword lane uses addr[1] only, which also gives forced alignment when not trapping.
    assign byte_sh = {addr_q[1:0], 3'b000};
    assign half_sh = {addr_q[1], 4'b0000};
    assign byte_ln = rbuf[byte_sh +: 8];
    assign half_ln = rbuf[half_sh +: 16];

    always_comb begin
        merge_wd = rbuf;
        if (f3_q[0]) merge_wd[half_sh +: 16] = wdata_q[15:0];
        else         merge_wd[byte_sh +: 8]  = wdata_q[7:0];
    end

    always_comb begin
        case (f3_q)
            3'b000:  load_data = {{(DATA_W-8){byte_ln[7]}}, byte_ln};
            3'b001:  load_data = {{(DATA_W-16){half_ln[15]}}, half_ln};
            3'b100:  load_data = {{(DATA_W-8){1'b0}}, byte_ln};
            3'b101:  load_data = {{(DATA_W-16){1'b0}}, half_ln};
            default: load_data = rbuf;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.mem_A     = '0;
        bus.mem_WE    = 1'b0;
        bus.mem_WD    = '0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        case (state)
            READ: bus.mem_A = addr_q >> 2;
            WRITE: begin
                bus.mem_A  = addr_q >> 2;
                bus.mem_WE = 1'b1;
                bus.mem_WD = (f3_q[1:0] == 2'b10) ? wdata_q : merge_wd;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = err_q;
                if (!err_q && !we_q) bus.rsp_rdata = load_data;
            end
            default: ;
        endcase
    end
endmodule
